// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
//
// Shared constants and helpers for the pipelined multiply-accumulate block.
// Neighbouring blocks import this package so that they can align their own
// strobes with the MAC output without hard-coding its latency.
//
// Contents:
//   clog2       - ceiling log2 of a positive integer (1 for value <= 1)
//   prod_width  - full unsigned product width for given operand widths
//   mac_lat     - input-sample to out_valid latency in cycles
//   DEF_*       - default parameter values of pipelined_mac_acc
//   PROD_WIDTH  - product width for the default operand widths
//   LAT         - latency for the default multiplier width
// ---------------------------------------------------------------------------
package mac_pkg;

    localparam int DEF_A_WIDTH   = 4;
    localparam int DEF_B_WIDTH   = 4;
    localparam int DEF_ACC_WIDTH = 16;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

    function automatic int prod_width(input int a_width, input int b_width);
        return a_width + b_width;
    endfunction

    // One register per partial-product row, plus the accumulate register
    // that also drives out_valid.
    function automatic int mac_lat(input int b_width);
        return b_width + 1;
    endfunction

    localparam int PROD_WIDTH = prod_width(DEF_A_WIDTH, DEF_B_WIDTH);
    localparam int LAT        = mac_lat(DEF_B_WIDTH);

endpackage

// File: rtl/mac_pp_stage.sv
// ---------------------------------------------------------------------------
// mac_pp_stage
//
// One row of the unsigned array multiplier. Stage K adds the K-th partial
// product row (a AND b[K], shifted left by K) to the running partial sum and
// registers it together with the operands and framing bits that later
// stages still need.
//
// Handshake: valid_in qualifies a_in/b_in/sum_in/last_in in the same cycle.
// There is no backpressure; every stage accepts whatever arrives. A bubble
// (valid_in=0) moves through as valid_out=0 and the data registers keep
// their previous contents, which downstream logic must treat as don't-care.
//
// Ports:
//   clk, reset         - rising-edge clock, synchronous active-high reset
//   valid_in, last_in  - framing bits from the previous stage
//   a_in, b_in         - multiplicand and multiplier travelling with the sum
//   sum_in             - partial sum P_(K-1) (all zeros for K=0)
//   valid_out, last_out, a_out, b_out, sum_out - registered copies; sum_out
//                        holds P_K
// ---------------------------------------------------------------------------
module mac_pp_stage
    import mac_pkg::*;
#(
    parameter int A_WIDTH = 4,
    parameter int B_WIDTH = 4,
    parameter int K       = 0
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     valid_in,
    input  logic                                     last_in,
    input  logic [A_WIDTH-1:0]                       a_in,
    input  logic [B_WIDTH-1:0]                       b_in,
    input  logic [prod_width(A_WIDTH, B_WIDTH)-1:0]  sum_in,
    output logic                                     valid_out,
    output logic                                     last_out,
    output logic [A_WIDTH-1:0]                       a_out,
    output logic [B_WIDTH-1:0]                       b_out,
    output logic [prod_width(A_WIDTH, B_WIDTH)-1:0]  sum_out
);

    localparam int PW = prod_width(A_WIDTH, B_WIDTH);

    logic [PW-1:0] row;
    logic [PW-1:0] sum_next;

    // The row only occupies bits [A_WIDTH+K-1:K]; the add result fits in
    // A_WIDTH+K+1 bits, so holding it at the full product width never loses
    // information.
    always_comb begin
        row      = '0;
        if (b_in[K]) begin
            row = PW'(a_in) << K;
        end
        sum_next = sum_in + row;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            sum_out   <= '0;
        end else begin
            valid_out <= valid_in;
            // Data only moves with a valid sample; bubbles leave it alone.
            if (valid_in) begin
                last_out <= last_in;
                a_out    <= a_in;
                b_out    <= b_in;
                sum_out  <= sum_next;
            end
        end
    end

endmodule

// File: rtl/pipelined_mac_acc.sv
// ---------------------------------------------------------------------------
// pipelined_mac_acc
//
// Streaming unsigned multiply-accumulate. Each valid operand pair is
// multiplied in a B_WIDTH-stage array multiplier (one partial-product row per
// stage) and the product is added to a group accumulator. in_last closes the
// group: the final sum is presented on out_acc with a one-cycle out_valid
// strobe, and the accumulator restarts at zero for the next pair.
//
// Handshake: in_valid qualifies in_a, in_b and in_last in the same cycle.
// There is no ready; the block accepts one pair every cycle. out_valid is a
// single-cycle strobe; out_acc and out_overflow hold their value until the
// next strobe.
//
// Latency: a pair sampled at edge t updates the accumulator at edge t+B_WIDTH;
// out_valid is high in the following cycle (mac_lat(B_WIDTH) cycles).
//
// Overflow: the accumulator add is done one bit wider than ACC_WIDTH; the
// carry-out is made sticky across the group. With SATURATE=1 a group that
// overflowed stays at all-ones; with SATURATE=0 it wraps modulo 2^ACC_WIDTH.
//
// Ports:
//   clk, reset    - rising-edge clock, synchronous active-high reset
//   in_valid      - operand pair valid
//   in_a, in_b    - multiplicand / multiplier (unsigned)
//   in_last       - with in_valid, ends the current group
//   out_valid     - group result strobe
//   out_acc       - group sum (held between strobes)
//   out_overflow  - group overflowed (held between strobes)
// ---------------------------------------------------------------------------
module pipelined_mac_acc
    import mac_pkg::*;
#(
    parameter int A_WIDTH   = DEF_A_WIDTH,
    parameter int B_WIDTH   = DEF_B_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [A_WIDTH-1:0]   in_a,
    input  logic [B_WIDTH-1:0]   in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic                 out_overflow
);

    localparam int PW = prod_width(A_WIDTH, B_WIDTH);

    // Index k of each chain is the input of stage k; index B_WIDTH is the
    // output of the last multiply stage.
    logic [B_WIDTH:0][PW-1:0]      sum_chain;
    logic [B_WIDTH:0][A_WIDTH-1:0] a_chain;
    logic [B_WIDTH:0][B_WIDTH-1:0] b_chain;
    logic [B_WIDTH:0]              valid_chain;
    logic [B_WIDTH:0]              last_chain;

    assign sum_chain[0]   = '0;
    assign a_chain[0]     = in_a;
    assign b_chain[0]     = in_b;
    assign valid_chain[0] = in_valid;
    assign last_chain[0]  = in_last;

    for (genvar k = 0; k < B_WIDTH; k++) begin : g_stage
        mac_pp_stage #(
            .A_WIDTH (A_WIDTH),
            .B_WIDTH (B_WIDTH),
            .K       (k)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .valid_in  (valid_chain[k]),
            .last_in   (last_chain[k]),
            .a_in      (a_chain[k]),
            .b_in      (b_chain[k]),
            .sum_in    (sum_chain[k]),
            .valid_out (valid_chain[k+1]),
            .last_out  (last_chain[k+1]),
            .a_out     (a_chain[k+1]),
            .b_out     (b_chain[k+1]),
            .sum_out   (sum_chain[k+1])
        );
    end

    // The operands leaving the last stage have no consumer.
    logic unused_chain_tail;
    assign unused_chain_tail = ^{a_chain[B_WIDTH], b_chain[B_WIDTH]};

    logic [PW-1:0] product;
    logic          product_valid;
    logic          product_last;

    assign product       = sum_chain[B_WIDTH];
    assign product_valid = valid_chain[B_WIDTH];
    assign product_last  = last_chain[B_WIDTH];

    // Running group state. Clearing acc_q/sticky_q when a group closes is
    // what makes the next pair start from acc_base = 0.
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 sticky_q;

    logic [ACC_WIDTH:0]   sum_wide;
    logic                 ovf_now;
    logic [ACC_WIDTH-1:0] acc_next;

    always_comb begin
        sum_wide = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - PW){1'b0}}, product};
        ovf_now  = sum_wide[ACC_WIDTH] | sticky_q;
        acc_next = sum_wide[ACC_WIDTH-1:0];
        // Once saturated the group stays pinned at all-ones even when later
        // products are zero and produce no fresh carry.
        if (SATURATE && ovf_now) begin
            acc_next = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q        <= '0;
            sticky_q     <= 1'b0;
            out_valid    <= 1'b0;
            out_acc      <= '0;
            out_overflow <= 1'b0;
        end else begin
            out_valid <= product_valid & product_last;
            if (product_valid) begin
                if (product_last) begin
                    out_acc      <= acc_next;
                    out_overflow <= ovf_now;
                    acc_q        <= '0;
                    sticky_q     <= 1'b0;
                end else begin
                    acc_q    <= acc_next;
                    sticky_q <= ovf_now;
                end
            end
        end
    end

endmodule

// File: doc/pipelined_mac_acc.md
Name: pipelined_mac_acc

Overview:
- Parametrised successor to the 4x4 bit-level pipelined multiplier, with a real accumulate stage.
- Unsigned A_WIDTH x B_WIDTH array multiplier, one partial-product row per pipeline stage, feeding an ACC_WIDTH accumulator.
- Accumulation is framed into groups by in_last; a completed dot product is emitted with a valid strobe and an overflow flag.
- Sits between the operand BRAM readers and the ILA/output logic; fully streaming, one operand pair per clock, no backpressure.

Parameters:
- A_WIDTH, 4, multiplicand width (unsigned), >=2
- B_WIDTH, 4, multiplier width (unsigned), >=2; also equals the number of multiply stages
- ACC_WIDTH, 16, accumulator/result width, >= A_WIDTH+B_WIDTH
- SATURATE, 1, 1 = clamp to all-ones on overflow; 0 = modulo 2^ACC_WIDTH wrap

Ports:
- clk  in  1  clock, all logic on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- in_valid  in  1  operand pair valid this cycle
- in_a  in  A_WIDTH  multiplicand
- in_b  in  B_WIDTH  multiplier
- in_last  in  1  qualifies in_valid; the product ends the current accumulation group
- out_valid  out  1  one-cycle strobe; the group result is on out_acc
- out_acc  out  ACC_WIDTH  accumulated group sum; held between strobes
- out_overflow  out  1  sticky over the group; valid with out_valid, held between strobes

Behaviour:
- Reset: all pipeline registers, valid/last shift bits, accumulator, out_valid, out_acc and out_overflow go to 0 on the first edge with reset=1. reset dominates every other input. Reset mid-group discards the partial sum, and no out_valid is produced for operands still in flight.
- Stage k (k=0..B_WIDTH-1):
  - Stage k registers the partial sum P_k = P_(k-1) + (a & {A_WIDTH{b[k]}}) << k, with P_-1 = 0.
  - Width of P_k is A_WIDTH+k+1, truncated to A_WIDTH+B_WIDTH.
  - a, the remaining b bits, valid and last travel alongside in a shift chain.
  - Each stage registers only on its own valid bit being 1. Bubbles propagate with valid=0 and leave data don't-care.
- Accumulate stage, when the stage-(B_WIDTH-1) valid bit = 1:
  - sum = acc_base + product, computed at ACC_WIDTH+1 bits.
  - acc_base = 0 if the previous accepted product was last (or after reset), else the running accumulator.
  - ovf = carry-out of that sum, OR the group's sticky overflow bit.
  - SATURATE=1 with the carry set: the stored value becomes all-ones and further adds keep it all-ones. SATURATE=0: the stored value wraps modulo 2^ACC_WIDTH.
- Output:
  - If the product at the accumulate stage has last=1: out_valid=1 for one cycle, out_acc=final sum, out_overflow=group ovf. The accumulator and sticky bit are restarted for the next group.
  - Otherwise out_valid=0.
- Latency: an operand pair sampled at edge t (in_valid=1) produces its accumulator update at edge t+B_WIDTH. out_valid for a last sample is high in the cycle after edge t+B_WIDTH, so LAT = B_WIDTH+1 cycles (default 5).
- Throughput: 1 pair/cycle. Back-to-back groups need no gap: the first pair of the next group may follow the last pair of the previous one on the very next cycle.
- in_last with in_valid=0 is ignored.
- A single-element group (first pair has in_last=1) emits that product alone.
- Gaps (in_valid=0) inside a group do not affect the sum.

Decomposition:
- Shared package mac_pkg: function clog2, localparam PROD_WIDTH = A_WIDTH+B_WIDTH, and the LAT computation, so neighbouring blocks can align strobes.
- One natural sub-module: mac_pp_stage.
  - Parametrised by A_WIDTH, B_WIDTH and stage index K.
  - Holds one partial-product row add plus its registers: sum, a, b, valid, last.
  - Instantiated B_WIDTH times in a generate loop.
- The accumulate/saturate logic stays in the top module.

Test Plan:
- Reset, then one pair in_a=15, in_b=15, in_last=1 -> out_valid exactly 5 cycles later, out_acc=225, out_overflow=0; out_valid=0 on all other cycles.
- Pairs (3,4), (5,6), (7,2 last) back-to-back -> a single strobe with out_acc=56, LAT cycles after the last pair.
- Two adjacent groups, {(1,1),(2,2) last} then {(15,1) last} with no gap -> strobes on consecutive-relevant cycles with out_acc=5 then 15. The second group is not polluted by the first.
- ACC_WIDTH=8, SATURATE=1, pairs (15,15),(15,15 last) -> out_acc=255, out_overflow=1. Same with SATURATE=0 -> out_acc=194, out_overflow=1. The next group (1,1 last) -> out_acc=1, out_overflow=0.
- Group {(2,3), bubble, bubble, (4,5) last} -> out_acc=26, with timing measured from the last pair.
- Pair (9,9) then reset asserted 2 cycles later for 1 cycle -> no out_valid ever. A following (2,2 last) -> out_acc=4, out_overflow=0.
